// File: rtl/cp0_intc_pkg.sv
// Shared CP0 interrupt-unit constants: register numbers, SR/Cause bit
// positions and the default processor ID.
package cp0_intc_pkg;

   localparam logic [4:0] REG_SR    = 5'd12;
   localparam logic [4:0] REG_CAUSE = 5'd13;
   localparam logic [4:0] REG_EPC   = 5'd14;
   localparam logic [4:0] REG_PRID  = 5'd15;

   localparam int unsigned IM_HI   = 15;
   localparam int unsigned IM_LO   = 10;
   localparam int unsigned EXL_BIT = 1;
   localparam int unsigned IE_BIT  = 0;
   localparam int unsigned IP_HI   = 15;
   localparam int unsigned IP_LO   = 10;

   localparam logic [31:0] PRID_DEFAULT = 32'h0000_4350;

endpackage

// File: rtl/cp0_intc.sv
// Coprocessor-0 interrupt unit: SR/Cause/EPC/PrID, synchronised device
// interrupt requests, ack handshake with EPC capture, mfc0/mtc0 and eret.
module cp0_intc
   import cp0_intc_pkg::*;
#(
   parameter logic [31:0] PRID = PRID_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [5:0]  hwint,
   input  logic [4:0]  addr,
   input  logic [31:0] din,
   input  logic        we,
   output logic [31:0] dout,
   input  logic [29:0] pc,
   input  logic        int_ack,
   input  logic        eret,
   output logic        intreq,
   output logic [29:0] epc
);

   logic [5:0]  ip;
   logic [5:0]  im;
   logic        exl;
   logic        ie;
   logic [29:0] epc_q;

   logic sr_we;
   logic epc_we;
   logic ack;
   logic din_unused;

   assign sr_we      = we && (addr == REG_SR);
   assign epc_we     = we && (addr == REG_EPC);
   assign ack        = int_ack && intreq;
   assign din_unused = ^{din[31:16], din[9:2]};

   assign intreq = (|(ip & im)) & ie & ~exl;
   assign epc    = epc_q;

   // Later assignments win: mtc0 < eret < ack for EXL, mtc0 < ack for EPC.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ip    <= '0;
         im    <= '0;
         exl   <= 1'b0;
         ie    <= 1'b0;
         epc_q <= '0;
      end else begin
         ip <= hwint;
         if (sr_we) begin
            im  <= din[IM_HI:IM_LO];
            exl <= din[EXL_BIT];
            ie  <= din[IE_BIT];
         end
         if (eret) exl <= 1'b0;
         if (ack)  exl <= 1'b1;
         if (ack)
            epc_q <= pc;
         else if (epc_we)
            epc_q <= din[31:2];
      end
   end

   always_comb begin
      dout = '0;
      case (addr)
         REG_SR: begin
            dout[IM_HI:IM_LO] = im;
            dout[EXL_BIT]     = exl;
            dout[IE_BIT]      = ie;
         end
         REG_CAUSE: dout[IP_HI:IP_LO] = ip;
         REG_EPC:   dout[31:2]        = epc_q;
         REG_PRID:  dout              = PRID;
         default:   dout              = '0;
      endcase
   end

endmodule

// File: tb/tb_cp0_intc.sv
// Directed bench for cp0_intc with a queue scoreboard of expected values.
module tb_cp0_intc;

   logic        clk;
   logic        reset;
   logic [5:0]  hwint;
   logic [4:0]  addr;
   logic [31:0] din;
   logic        we;
   logic [31:0] dout;
   logic [29:0] pc;
   logic        int_ack;
   logic        eret;
   logic        intreq;
   logic [29:0] epc;

   typedef struct {
      string       tag;
      logic [31:0] exp;
   } sb_item_t;

   sb_item_t sb[$];
   int checks   = 0;
   int failures = 0;

   cp0_intc #(.PRID(32'h0000_4350)) dut (
      .clk     (clk),
      .reset   (reset),
      .hwint   (hwint),
      .addr    (addr),
      .din     (din),
      .we      (we),
      .dout    (dout),
      .pc      (pc),
      .int_ack (int_ack),
      .eret    (eret),
      .intreq  (intreq),
      .epc     (epc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic expect_val(input string tag, input logic [31:0] v);
      sb_item_t it;
      it.tag = tag;
      it.exp = v;
      sb.push_back(it);
   endtask

   task automatic check(input logic [31:0] obs);
      sb_item_t it;
      checks++;
      if (sb.size() == 0) begin
         failures++;
         $error("FAIL sb_underflow got=%h", obs);
      end else begin
         it = sb.pop_front();
         assert (obs === it.exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", it.tag, obs, it.exp);
         end
      end
   endtask

   task automatic rd(input string tag, input logic [4:0] a, input logic [31:0] v);
      expect_val(tag, v);
      addr = a;
      #1;
      check(dout);
   endtask

   task automatic chk_req(input string tag, input logic v);
      expect_val(tag, {31'b0, v});
      check({31'b0, intreq});
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; hwint = '0; addr = '0; din = '0; we = 1'b0;
      pc = '0; int_ack = 1'b0; eret = 1'b0;
      tick; tick;
      reset = 1'b0;
      tick;

      chk_req("rst_intreq", 1'b0);
      expect_val("rst_epc", 32'h0); check({2'b0, epc});
      rd("rst_sr",    5'd12, 32'h0);
      rd("rst_cause", 5'd13, 32'h0);
      rd("rst_epcr",  5'd14, 32'h0);
      rd("rst_prid",  5'd15, 32'h0000_4350);
      tick;

      // Enable IM[10] and IE, then raise hwint[0]
      addr = 5'd12; din = 32'h0000_0401; we = 1'b1;
      tick;
      we = 1'b0;
      rd("sr_wr", 5'd12, 32'h0000_0401);
      hwint = 6'b000001;
      chk_req("req_before_sample", 1'b0);
      tick;
      chk_req("req_after_sample", 1'b1);
      rd("cause_ip", 5'd13, 32'h0000_0400);

      // Acknowledge: EPC captured, EXL set
      pc = 30'h0000_0C05; int_ack = 1'b1;
      tick;
      int_ack = 1'b0;
      chk_req("ack_drop", 1'b0);
      rd("ack_epc", 5'd14, 32'h0000_3014);
      rd("ack_sr",  5'd12, 32'h0000_0403);
      expect_val("ack_epc_port", 32'h0000_0C05); check({2'b0, epc});

      // eret with hwint still high re-requests
      eret = 1'b1;
      tick;
      eret = 1'b0;
      chk_req("eret_rereq", 1'b1);
      rd("eret_sr", 5'd12, 32'h0000_0401);
      rd("eret_epc_kept", 5'd14, 32'h0000_3014);

      // Ack, drop hwint, then eret: no re-request
      pc = 30'h0000_0100; int_ack = 1'b1;
      tick;
      int_ack = 1'b0;
      rd("ack2_epc", 5'd14, 32'h0000_0400);
      hwint = 6'b0;
      tick;
      eret = 1'b1;
      tick;
      eret = 1'b0;
      chk_req("eret_no_rereq", 1'b0);
      rd("eret2_sr", 5'd12, 32'h0000_0401);

      // Ack while intreq low is ignored
      pc = 30'h0000_0777; int_ack = 1'b1;
      tick;
      int_ack = 1'b0;
      rd("spur_ack_epc", 5'd14, 32'h0000_0400);
      rd("spur_ack_sr",  5'd12, 32'h0000_0401);
      rd("unmapped_reg", 5'd3,  32'h0);

      // Ack and mtc0 EPC on the same edge: ack wins
      hwint = 6'b000001;
      tick;
      chk_req("req3", 1'b1);
      pc = 30'h0000_0ABC; int_ack = 1'b1;
      addr = 5'd14; din = 32'hFFFF_FFFC; we = 1'b1;
      tick;
      int_ack = 1'b0; we = 1'b0;
      rd("ack_vs_epc_wr", 5'd14, 32'h0000_2AF0);
      chk_req("ack3_drop", 1'b0);

      // Ack and mtc0 SR on the same edge: IM/IE from din, EXL set
      eret = 1'b1;
      tick;
      eret = 1'b0;
      chk_req("req4", 1'b1);
      pc = 30'h0000_0010; int_ack = 1'b1;
      din = 32'h0000_0801; we = 1'b1;
      rd("rd_during_wr_old", 5'd12, 32'h0000_0401);
      tick;
      int_ack = 1'b0; we = 1'b0;
      rd("ack_vs_sr_wr", 5'd12, 32'h0000_0803);
      rd("ack4_epc",     5'd14, 32'h0000_0040);

      // eret and mtc0 SR on the same edge: EXL cleared despite din[1]
      eret = 1'b1; addr = 5'd12; din = 32'h0000_0403; we = 1'b1;
      tick;
      eret = 1'b0; we = 1'b0;
      rd("eret_vs_sr_wr", 5'd12, 32'h0000_0401);
      chk_req("req5", 1'b1);

      // Async reset mid-handshake; ack held during reset must not capture
      #2;
      reset = 1'b1; int_ack = 1'b1; pc = 30'h0000_0555;
      #1;
      chk_req("async_rst_req", 1'b0);
      expect_val("async_rst_epc", 32'h0); check({2'b0, epc});
      rd("async_rst_sr",    5'd12, 32'h0);
      rd("async_rst_cause", 5'd13, 32'h0);
      tick;
      int_ack = 1'b0;
      rd("rst_no_capture", 5'd14, 32'h0);
      reset = 1'b0;
      tick;
      chk_req("post_rst_req", 1'b0);

      if (sb.size() != 0) begin
         checks++;
         failures++;
         $error("FAIL sb_leftover got=%0d exp=0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cp0_intc.md
# cp0_intc

Coprocessor-0 interrupt unit: the CPU-side receiver of the six `intq` lines that the bridge collects from the timers and other devices. It holds the MIPS SR, Cause, EPC and PrID registers. It synchronises and masks device interrupt requests and asserts a request to the pipeline. It then completes an acknowledge handshake that captures the EPC. It also services mfc0/mtc0 accesses and `eret` from the mips core.

## Interface
Parameters:
- `PRID`, 32'h0000_4350: read-only value of register 15.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `hwint`  in  6  device interrupt lines from the bridge; level-sensitive, asynchronous to the pipeline.
- `addr`  in  5  CP0 register number for mfc0/mtc0.
- `din`  in  32  mtc0 write data.
- `we`  in  1  mtc0 write strobe, one cycle per write.
- `dout`  out  32  mfc0 read data; combinational from `addr`.
- `pc`  in  30  word address `[31:2]` of the instruction to resume after the interrupt.
- `int_ack`  in  1  pipeline accepts the interrupt this cycle.
- `eret`  in  1  exception return, one cycle.
- `intreq`  out  1  interrupt request to the pipeline.
- `epc`  out  30  current EPC `[31:2]`, for the `eret` redirect.

## Operation
- SR (reg 12):
  - IM = bits [15:10], EXL = bit 1, IE = bit 0.
  - All other bits read 0 and ignore writes.
- Cause (reg 13):
  - IP = bits [15:10], read-only; all other bits read 0.
  - ExcCode [6:2] is always 0 (interrupt).
- EPC (reg 14): bits [31:2] are writable; bits [1:0] read 0.
- PrID (reg 15) returns `PRID`.
- Any other `addr` reads 0. Writes to any register other than 12 and 14 are ignored.
- IP is a register loaded from `hwint` every cycle. IP is not sticky: the handler must clear the interrupt at the device.
- Request: `intreq = |(IP & IM) & IE & ~EXL`, combinational from registers only, never directly from `hwint`.
- Handshake:
  - `intreq` stays high until `int_ack`.
  - On an edge with `int_ack`=1, EPC <= `pc` and EXL <= 1.
  - Because EXL is then set, `intreq` is low from the next cycle.
  - `int_ack` while `intreq`=0 is ignored; state is unchanged.
- `eret`: EXL <= 0 at the edge. EPC is unchanged.
- Simultaneous events, same edge:
  - `int_ack` + mtc0 to SR: IM and IE take `din`; EXL is set to 1 (ack wins).
  - `int_ack` + mtc0 to EPC: EPC <= `pc` (ack wins).
  - `int_ack` + `eret`: EXL <= 1 and EPC <= `pc` (ack wins; the pipeline must not do this).
  - `eret` + mtc0 to SR: IM and IE take `din`; EXL <= 0.
- Reset values:
  - SR = 0 (interrupts disabled), IP = 0, EPC = 0.
  - Outputs: `intreq` = 0, `epc` = 0, `dout` = PrID if `addr`=15, otherwise the value of the selected register (0 after reset).

## Timing
- `hwint` to `intreq` latency is 1 cycle: `hwint` is sampled at edge N, and `intreq` is high after edge N if it is unmasked.
- mtc0 takes effect from the next cycle. A write setting IE with a pending IP raises `intreq` one cycle after the `we` edge.
- mfc0 `dout` reflects writes from the previous edge. A read in the same cycle as a write returns the old value.
- `int_ack` to `intreq` low: 1 edge. `eret` to re-request: the cycle after the `eret` edge, if IP&IM is still nonzero.
- Reset mid-handshake (`intreq` high, no ack yet): everything clears asynchronously. No EPC capture occurs.

## Structure
- Shared package: register numbers (12/13/14/15) and SR/Cause bit positions (IM_HI/IM_LO, EXL, IE, IP_HI/IP_LO).
- The `PRID` default also lives in the shared package.
- No sub-module; a single flat block instantiated in `mips` and fed by the bridge's `intq_cpu`.

## Test plan
- Reset, then read regs 12/13/14/15 -> 0, 0, 0, 32'h0000_4350; `intreq`=0.
- mtc0 SR=32'h0000_0401 (IM[10], IE); raise `hwint`=6'b000001 -> `intreq` high 1 cycle later; Cause reads 32'h0000_0400.
- With `intreq` high, `pc`=30'h0000_0C05 and `int_ack` -> next cycle EPC reads 32'h0000_3014, SR reads 32'h0000_0403, and `intreq`=0.
- Keep `hwint` high and pulse `eret` -> EXL clears; `intreq` reasserts the cycle after the `eret` edge.
- Drop `hwint` before `eret` -> `intreq` stays 0 after `eret`.
- `int_ack` with mtc0 EPC=32'hFFFF_FFFC on the same edge -> EPC = `pc`; assert async `reset` while `intreq` is high -> all registers 0 immediately.
